// File: rtl/cam_read.sv
// OV7670 capture front-end: oversampled RGB565 byte pairs -> RGB444 writes into a
// H_PIX x V_LIN frame buffer. Define CAM_TEST_PATTERN_EN to write colour bars instead.
module cam_read #(
  parameter int H_PIX = 160,
  parameter int V_LIN = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          PCLK,
  input  logic [7:0]    D,
  input  logic          capture_en,
  output logic [AW-1:0] mem_addr,
  output logic [11:0]   mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          busy
);

  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LIN + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t state, state_n;

  logic [1:0]      pclk_sync, href_sync, vs_sync;
  logic [1:0][7:0] d_sync;
  logic            pclk_q, href_q, vs_q;
  logic            pclk_s, href_s, vs_s;
  logic [7:0]      d_s;
  logic            pclk_rise, href_fall, vs_rise, vs_fall;

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [AW-1:0]   line_base;
  logic            phase;
  logic [6:0]      byte1;
  logic            wr;
  logic [11:0]     pix_c, pix_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      vld_pipe;

  // All four inputs share the same depth so bytes stay aligned with PCLK/HREF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sync <= '0;
      href_sync <= '0;
      vs_sync   <= '0;
      d_sync    <= '0;
      pclk_q    <= 1'b0;
      href_q    <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      pclk_sync <= {pclk_sync[0], PCLK};
      href_sync <= {href_sync[0], HREF};
      vs_sync   <= {vs_sync[0], VSYNC};
      d_sync    <= {d_sync[0], D};
      pclk_q    <= pclk_sync[1];
      href_q    <= href_sync[1];
      vs_q      <= vs_sync[1];
    end
  end

  assign pclk_s    = pclk_sync[1];
  assign href_s    = href_sync[1];
  assign vs_s      = vs_sync[1];
  assign d_s       = d_sync[1];
  assign pclk_rise = pclk_s & ~pclk_q;
  assign href_fall = href_q & ~href_s;
  assign vs_rise   = vs_s & ~vs_q;
  assign vs_fall   = vs_q & ~vs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture_en) state_n = WAIT_VS;
      WAIT_VS: if (vs_fall)    state_n = CAPTURE;
      CAPTURE: if (vs_rise)    state_n = DONE;
      DONE:                    state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  assign busy       = (state == CAPTURE);
  assign frame_done = (state == DONE);

  // Frame-end and line-end take priority over a coincident byte
  assign wr = busy && !vs_rise && !href_fall && pclk_rise && href_s && phase &&
              (x < XW'(H_PIX)) && (y < YW'(V_LIN));

`ifdef CAM_TEST_PATTERN_EN
  logic [2:0] bar;
  logic       unused_cam;
  assign bar        = 3'(x >> 5);
  assign unused_cam = &{1'b0, d_s, byte1};
  always_comb begin
    pix_c = 12'h000;
    case (bar)
      3'd0: pix_c = 12'hFFF;
      3'd1: pix_c = 12'hFF0;
      3'd2: pix_c = 12'h0FF;
      3'd3: pix_c = 12'h0F0;
      3'd4: pix_c = 12'hF0F;
      3'd5: pix_c = 12'hF00;
      3'd6: pix_c = 12'h00F;
      default: pix_c = 12'h000;
    endcase
  end
`else
  logic unused_d;
  assign unused_d = &{1'b0, d_s[6:5], d_s[0]};
  assign pix_c    = {byte1[6:3], byte1[2:0], d_s[7], d_s[4:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      phase     <= 1'b0;
      byte1     <= '0;
    end else if (!busy) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      phase     <= 1'b0;
    end else if (vs_rise) begin
      phase <= 1'b0;
    end else if (href_fall) begin
      if (x != '0 && y < YW'(V_LIN)) begin
        y         <= y + 1'b1;
        line_base <= line_base + AW'(H_PIX);
      end
      x     <= '0;
      phase <= 1'b0;
    end else if (pclk_rise && href_s) begin
      if (!phase) begin
        byte1 <= {d_s[7:4], d_s[2:0]};
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        // saturate: pixels past H_PIX are dropped anyway
        if (x != XW'(H_PIX)) x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      pix_q    <= '0;
      addr_q   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], wr};
      if (wr) begin
        pix_q  <= pix_c;
        addr_q <= line_base + AW'(x);
      end
      if (vld_pipe[0]) begin
        mem_addr <= addr_q;
        mem_data <= pix_q;
      end
    end
  end

  assign mem_we = vld_pipe[1];

endmodule

// File: doc/cam_read.md
Name: cam_read

Overview:
- Capture front-end between the OV7670 pins and the frame buffer that feeds the VGA path in test_cam.
- Oversamples the camera's PCLK/HREF/VSYNC/D on the system clock.
- Assembles RGB565 byte pairs into RGB444 pixels and issues single-cycle writes into a QQVGA (160x120) buffer.
- Frames are gated by a capture enable driven from CBtn.

Parameters:
- H_PIX, 160, active pixels per line written to buffer.
- V_LIN, 120, active lines per frame written to buffer.
- AW, 15, buffer address width; must satisfy 2^AW >= H_PIX*V_LIN.

Ports:
- clk  in  1  system clock; required frequency >= 4x PCLK.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- VSYNC  in  1  camera frame sync; high pulse between frames.
- HREF  in  1  camera line valid.
- PCLK  in  1  camera pixel clock; sampled as data, never used as a clock.
- D  in  8  camera data byte.
- capture_en  in  1  level; 1 = capture frames continuously, 0 = hold the last frame.
- mem_addr  out  AW  buffer write address.
- mem_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- mem_we  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- busy  out  1  high while a frame is being captured.

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; all counters 0; byte phase 0.

Input synchronisation:
- PCLK, HREF, VSYNC and D each pass through identical 2-flop synchronisers, so they stay mutually aligned.
- pclk_rise = sync PCLK high AND previous sync PCLK low (3rd flop). All byte sampling happens only on pclk_rise.
- Input-to-mem_we latency: 4 clk cycles after the PCLK rising edge that carries byte 2.

FSM states:
- IDLE: busy=0. Go to WAIT_VS when capture_en=1. capture_en is sampled only in IDLE.
- WAIT_VS: wait for the synced VSYNC falling edge, then go to CAPTURE. Clear x, y, addr and phase on entry.
- CAPTURE: busy=1.
  - On pclk_rise with HREF=1: if phase=0, latch byte1 and set phase=1. If phase=1, form the pixel, set phase=0 and write if x<H_PIX and y<V_LIN; x increments on every completed pixel.
  - Synced HREF falling edge: if x>0 then y+1. x=0, phase=0; a half pixel is discarded with no write.
  - Synced VSYNC rising edge: go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.

Pixel mapping (RGB565 to RGB444):
- R = byte1[7:4].
- G = {byte1[2:0], byte2[7]}.
- B = byte2[4:1].

Write rules:
- mem_addr = y*H_PIX + x, maintained incrementally with no multiplier. addr advances only on an actual write.
- Writes never exceed H_PIX*V_LIN-1. Excess pixels per line and excess lines are dropped silently.
- mem_data and mem_addr are held stable in the cycle mem_we=1 and keep their values afterwards.

Boundary conditions:
- VSYNC rising mid-line: the frame ends immediately; a pending byte1 is discarded.
- Simultaneous HREF fall and pclk_rise: the byte is ignored, because HREF is sampled low.
- capture_en dropping during CAPTURE: the current frame completes; the FSM then stays in IDLE.
- rst mid-frame: immediate return to IDLE with no write. The partial buffer contents are left as they are.

Optional Feature:
- Macro CAM_TEST_PATTERN_EN.
- Defined: in CAPTURE, mem_data is replaced by 8 vertical colour bars indexed by x[7:5]: 0=FFF, 1=FF0, 2=0FF, 3=0F0, 4=F0F, 5=F00, 6=00F, 7=000. Timing, addressing and strobes are unchanged, so the camera sync path is still exercised.
- Undefined: camera data only; no pattern logic is synthesised.

Test Plan:
- rst=1, then release with all inputs 0: all outputs 0, FSM IDLE. Hold 100 cycles: no mem_we.
- capture_en=1, one VSYNC pulse then 1 line of 2 bytes, D=8'hF8 then 8'h1F, HREF=1: exactly one write, addr=0, data=12'hF0F. A second pixel 8'h07/8'hE0 gives addr=1, data=12'h0F0.
- Full frame of 120 lines x 160 pixels, then VSYNC rising: 19200 writes, last addr=19199, frame_done one cycle, busy back to 0.
- Frame of 130 lines x 170 pixels: still 19200 writes, max addr 19199, no addr wrap.
- HREF falls after a single byte: no write, phase reset. The next line's first pixel lands at addr=H_PIX*y with the correct byte pairing.
- rst asserted mid-line: outputs clear asynchronously. The next capture restarts at addr=0 after the next VSYNC falling edge.
